// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, stage-1 record type and output field helper
// for the twiddle-multiply sequencer.
package fft_pkg;

  localparam int N_LOG2_DEF = 6;
  localparam int X_W        = 9;
  localparam int W_W        = 10;
  localparam int Y_W        = 20;
  localparam int OUT_W      = 15;
  localparam int TRUN_W     = 3;

  localparam logic signed [W_W-1:0] TW_ONE     = 10'sd256;
  localparam logic [TRUN_W-1:0]     TRUN_ROUND = 3'd4;
  localparam logic [TRUN_W-1:0]     TRUN_NONE  = 3'd0;

  localparam int OUT_SIGN = 19;
  localparam int OUT_MSB  = 16;
  localparam int OUT_LSB  = 3;

  typedef struct packed {
    logic           sof;
    logic           eof;
    logic           bypass;
    logic [X_W-1:0] x_r;
    logic [X_W-1:0] x_i;
  } s1_t;

  // Keep the sign bit and drop y[18:17]: overflow wraps instead of saturating.
  function automatic logic signed [OUT_W-1:0] out_field(input logic signed [Y_W-1:0] y);
    return {y[OUT_SIGN], y[OUT_MSB:OUT_LSB]};
  endfunction

endpackage

// File: rtl/tw_mult_sched_if.sv
// rtl/tw_mult_sched_if.sv - sample input stream and multiplied output stream
// bundled as one interface.
interface tw_mult_sched_if;
  import fft_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sof;
  logic signed [X_W-1:0]   in_r;
  logic signed [X_W-1:0]   in_i;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_sof;
  logic                    out_eof;
  logic signed [OUT_W-1:0] out_r;
  logic signed [OUT_W-1:0] out_i;

  modport master (
    output in_valid, in_sof, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_sof, out_eof, out_r, out_i
  );

  modport slave (
    input  in_valid, in_sof, in_r, in_i, out_ready,
    output in_ready, out_valid, out_sof, out_eof, out_r, out_i
  );

endinterface

// File: rtl/tw_mult_sched_multiplier_tw.sv
// rtl/tw_mult_sched_multiplier_tw.sv - combinational complex multiply by the
// twiddle, symmetric rounding and output field extraction.
module multiplier_tw
  import fft_pkg::*;
(
  input  logic signed [X_W-1:0]   x_r,
  input  logic signed [X_W-1:0]   x_i,
  input  logic signed [W_W-1:0]   w_r,
  input  logic signed [W_W-1:0]   w_i,
  input  logic [TRUN_W-1:0]       trun,
  output logic signed [OUT_W-1:0] y_r,
  output logic signed [OUT_W-1:0] y_i
);

  logic signed [Y_W-1:0] xr, xi, wr, wi, t;
  logic signed [Y_W-1:0] sum_r, sum_i, rnd_r, rnd_i;

  always_comb begin
    xr    = {{(Y_W-X_W){x_r[X_W-1]}}, x_r};
    xi    = {{(Y_W-X_W){x_i[X_W-1]}}, x_i};
    wr    = {{(Y_W-W_W){w_r[W_W-1]}}, w_r};
    wi    = {{(Y_W-W_W){w_i[W_W-1]}}, w_i};
    t     = {{(Y_W-TRUN_W){1'b0}}, trun};
    sum_r = xr * wr - xi * wi;
    sum_i = xr * wi + xi * wr;
    // Rounding moves away from zero, so negative sums subtract the constant.
    rnd_r = sum_r[Y_W-1] ? sum_r - t : sum_r + t;
    rnd_i = sum_i[Y_W-1] ? sum_i - t : sum_i + t;
    y_r   = out_field(rnd_r);
    y_i   = out_field(rnd_i);
  end

endmodule

// File: rtl/tw_mult_sched.sv
// rtl/tw_mult_sched.sv - frame sample counter, twiddle ROM addressing and the
// two-register pipeline around the shared twiddle multiplier.
module tw_mult_sched
  import fft_pkg::*;
#(
  parameter  int N_LOG2  = N_LOG2_DEF,
  localparam int STAGE_W = $clog2(N_LOG2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STAGE_W-1:0]    cfg_stage,
  input  logic                  cfg_round,
  tw_mult_sched_if.slave        strm,
  output logic                  tw_en,
  output logic [N_LOG2-2:0]     tw_addr,
  input  logic signed [W_W-1:0] tw_r,
  input  logic signed [W_W-1:0] tw_i,
  output logic                  err_sof
);

  logic                    advance, accept;
  logic [N_LOG2-1:0]       k_q, k_cur, span_mask;
  logic [STAGE_W-1:0]      stage_q, stage_cur, cfg_clamped;
  int                      span_log2;
  s1_t                     s1_q, s1_next;
  logic                    s1_valid;
  logic signed [W_W-1:0]   w_r, w_i;
  logic [TRUN_W-1:0]       trun;
  logic signed [OUT_W-1:0] y_r, y_i;

  always_comb begin
    advance     = !strm.out_valid || strm.out_ready;
    accept      = strm.in_valid && advance;
    cfg_clamped = (int'(cfg_stage) > N_LOG2 - 1) ? STAGE_W'(N_LOG2 - 1) : cfg_stage;
    // An SOF sample is index 0 and already uses the stage it latches.
    k_cur       = strm.in_sof ? '0 : k_q;
    stage_cur   = strm.in_sof ? cfg_clamped : stage_q;
    // The span L is 2**span_log2; bit span_log2 of k selects the half of each 2L block.
    span_log2   = N_LOG2 - 1 - int'(stage_cur);
    span_mask   = ~({N_LOG2{1'b1}} << span_log2);
    tw_addr     = (N_LOG2-1)'(k_cur & span_mask) << stage_cur;

    s1_next.sof    = (k_cur == '0);
    s1_next.eof    = &k_cur;
    s1_next.bypass = ((k_cur >> span_log2) & N_LOG2'(1)) == '0;
    s1_next.x_r    = strm.in_r;
    s1_next.x_i    = strm.in_i;

    w_r  = s1_q.bypass ? TW_ONE : tw_r;
    w_i  = s1_q.bypass ? '0     : tw_i;
    trun = cfg_round ? TRUN_ROUND : TRUN_NONE;
  end

  assign strm.in_ready = advance;
  assign tw_en         = accept;

  multiplier_tw u_multiplier_tw (
    .x_r  (signed'(s1_q.x_r)),
    .x_i  (signed'(s1_q.x_i)),
    .w_r  (w_r),
    .w_i  (w_i),
    .trun (trun),
    .y_r  (y_r),
    .y_i  (y_i)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q            <= '0;
      stage_q        <= '0;
      err_sof        <= 1'b0;
      s1_valid       <= 1'b0;
      s1_q           <= '0;
      strm.out_valid <= 1'b0;
      strm.out_sof   <= 1'b0;
      strm.out_eof   <= 1'b0;
      strm.out_r     <= '0;
      strm.out_i     <= '0;
    end else if (advance) begin
      s1_valid <= strm.in_valid;
      if (accept) begin
        s1_q <= s1_next;
        k_q  <= k_cur + 1'b1;
        if (strm.in_sof) begin
          stage_q <= cfg_clamped;
          err_sof <= err_sof || (k_q != '0);
        end
      end
      strm.out_valid <= s1_valid;
      strm.out_sof   <= s1_valid && s1_q.sof;
      strm.out_eof   <= s1_valid && s1_q.eof;
      if (s1_valid) begin
        strm.out_r <= y_r;
        strm.out_i <= y_i;
      end
    end
  end

endmodule

// File: tb/tb_tw_mult_sched.sv
// tb/tb_tw_mult_sched.sv - randomized directed phases against a frame-level
// reference model of the twiddle sequencer.
module tb_tw_mult_sched;

  localparam int NL = 3;
  localparam int N  = 1 << NL;
  localparam int SW = $clog2(NL);

  typedef struct {
    int r;
    int i;
    bit sof;
    bit eof;
    int cyc;
  } exp_t;

  logic              clk       = 1'b0;
  logic              rst       = 1'b1;
  logic [SW-1:0]     cfg_stage = '0;
  logic              cfg_round = 1'b0;
  logic              tw_en;
  logic [NL-2:0]     tw_addr;
  logic signed [9:0] tw_r      = '0;
  logic signed [9:0] tw_i      = '0;
  logic              err_sof;

  int   rom_r [N/2];
  int   rom_i [N/2];
  exp_t q [$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   k_m      = 0;
  int   stage_m  = 0;
  bit   err_m    = 1'b0;
  bit   lat_chk  = 1'b0;
  bit   prev_stall = 1'b0;
  int   prev_r, prev_i;
  bit   prev_sof, prev_eof;

  tw_mult_sched_if bus ();

  tw_mult_sched #(.N_LOG2(NL)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_stage (cfg_stage),
    .cfg_round (cfg_round),
    .strm      (bus),
    .tw_en     (tw_en),
    .tw_addr   (tw_addr),
    .tw_r      (tw_r),
    .tw_i      (tw_i),
    .err_sof   (err_sof)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tw_en) begin
      tw_r <= 10'(rom_r[tw_addr]);
      tw_i <= 10'(rom_i[tw_addr]);
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expd);
    n_assert++;
    assert (obs === expd) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expd);
    end
  endtask

  function automatic int model_out(input int y, input int t);
    int         yy;
    logic [19:0] w;
    yy = (y >= 0) ? y + t : y - t;
    w  = yy[19:0];
    return $signed({{17{w[19]}}, w[19], w[16:3]});
  endfunction

  task automatic step(output bit acc_in);
    exp_t e;
    bit   acc_out;
    int   kk, ss, span, addr, wr, wi, t;
    #1;
    acc_in  = bus.in_valid && bus.in_ready && !rst;
    acc_out = bus.out_valid && bus.out_ready && !rst;
    if (rst) begin
      q.delete();
      k_m        = 0;
      stage_m    = 0;
      err_m      = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
      chk("tw_en", tw_en, bus.in_valid && bus.in_ready);
      chk("err_sof", err_sof, err_m);
      if (prev_stall) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_r", bus.out_r, prev_r);
        chk("hold_i", bus.out_i, prev_i);
        chk("hold_sof", bus.out_sof, prev_sof);
        chk("hold_eof", bus.out_eof, prev_eof);
      end
      if (acc_out) begin
        chk("out_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("out_r", bus.out_r, e.r);
          chk("out_i", bus.out_i, e.i);
          chk("out_sof", bus.out_sof, e.sof);
          chk("out_eof", bus.out_eof, e.eof);
          if (lat_chk) chk("latency", cyc - e.cyc, 2);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_r     = bus.out_r;
      prev_i     = bus.out_i;
      prev_sof   = bus.out_sof;
      prev_eof   = bus.out_eof;
      if (acc_in) begin
        kk = bus.in_sof ? 0 : k_m;
        ss = bus.in_sof ? ((int'(cfg_stage) > NL - 1) ? NL - 1 : int'(cfg_stage)) : stage_m;
        if (bus.in_sof && k_m != 0) err_m = 1'b1;
        span = N >> (ss + 1);
        addr = (kk % span) << ss;
        if ((kk % (2 * span)) < span) begin
          wr = 256;
          wi = 0;
        end else begin
          chk("tw_addr", tw_addr, addr);
          wr = rom_r[addr];
          wi = rom_i[addr];
        end
        t     = cfg_round ? 4 : 0;
        e.r   = model_out(int'(bus.in_r) * wr - int'(bus.in_i) * wi, t);
        e.i   = model_out(int'(bus.in_r) * wi + int'(bus.in_i) * wr, t);
        e.sof = (kk == 0);
        e.eof = (kk == N - 1);
        e.cyc = cyc;
        q.push_back(e);
        k_m     = (kk + 1) % N;
        stage_m = ss;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input int n, input int sof_at, input int p_valid, input int p_ready,
                       input bit fixed, input int fr, input int fi);
    int got   = 0;
    int guard = 0;
    bit acc;
    while (got < n && guard < 2000) begin
      bus.in_valid  = ($urandom_range(99) < p_valid);
      bus.in_sof    = (got == sof_at);
      bus.in_r      = fixed ? 9'(fr) : 9'($urandom);
      bus.in_i      = fixed ? 9'(fi) : 9'($urandom);
      bus.out_ready = ($urandom_range(99) < p_ready);
      step(acc);
      if (acc) got++;
      guard++;
    end
    chk("drive_budget", guard < 2000, 1);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    bit acc;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b1;
    while ((q.size() != 0 || bus.out_valid) && g < 20) begin
      step(acc);
      g++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    #1;
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_sof"}, bus.out_sof, 0);
    chk({tag, "_out_eof"}, bus.out_eof, 0);
    chk({tag, "_out_r"}, bus.out_r, 0);
    chk({tag, "_out_i"}, bus.out_i, 0);
    chk({tag, "_err_sof"}, err_sof, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
  endtask

  task automatic randomize_rom();
    for (int a = 0; a < N / 2; a++) begin
      rom_r[a] = int'($urandom_range(1023)) - 512;
      rom_i[a] = int'($urandom_range(1023)) - 512;
    end
  endtask

  initial begin
    bit acc;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_r      = '0;
    bus.in_i      = '0;
    bus.out_ready = 1'b1;
    for (int a = 0; a < N / 2; a++) begin
      rom_r[a] = 256;
      rom_i[a] = 0;
    end
    @(negedge clk);
    step(acc);
    step(acc);
    rst = 1'b0;
    check_reset_state("reset");

    // Unity input through identity twiddles: every output is (32,0).
    lat_chk   = 1'b1;
    cfg_stage = 2'd0;
    drive(8, 0, 100, 100, 1'b1, 1, 0);
    drain();

    randomize_rom();
    for (int s = 1; s < 4; s++) begin
      cfg_stage = SW'(s);
      drive(8, 0, 70, 100, 1'b0, 0, 0);
      drain();
    end

    cfg_stage = 2'd0;
    cfg_round = 1'b0;
    drive(1, 0, 100, 100, 1'b1, 3, -3);
    drive(7, -1, 100, 100, 1'b0, 0, 0);
    drain();
    cfg_round = 1'b1;
    drive(1, 0, 100, 100, 1'b1, 3, -3);
    drive(7, -1, 100, 100, 1'b0, 0, 0);
    drain();

    lat_chk   = 1'b0;
    cfg_stage = 2'd1;
    randomize_rom();
    drive(24, 0, 80, 50, 1'b0, 0, 0);
    drain();

    // SOF arriving at k=3 restarts the count and raises the sticky error.
    cfg_round = 1'b0;
    cfg_stage = 2'd0;
    drive(3, 0, 100, 100, 1'b0, 0, 0);
    drive(6, 0, 90, 70, 1'b0, 0, 0);
    drain();

    // Two samples in flight when reset hits mid-frame.
    cfg_stage = 2'd2;
    drive(3, 0, 100, 100, 1'b0, 0, 0);
    bus.out_ready = 1'b1;
    drive(2, -1, 100, 100, 1'b0, 0, 0);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    step(acc);
    rst = 1'b0;
    check_reset_state("midreset");
    lat_chk = 1'b1;
    drive(8, -1, 100, 100, 1'b0, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
